// File: rtl/flash_pkg.sv
// Shared types and constants for the flash clock PLL supervisor.
package flash_pkg;

  localparam int unsigned CNT_W        = 16;
  localparam int unsigned RETRY_W      = 3;
  localparam int unsigned CNT_MAX_LOAD = 65536;

  localparam int unsigned DEF_PLL_RST_CYCLES = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT   = 50000;
  localparam int unsigned DEF_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_MAX_RETRIES    = 7;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous status inputs.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First flop may go metastable; second flop gives it a cycle to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/flash_pll_supervisor.sv
// Sequences PLL reset, lock wait and lock qualification before releasing
// the flash-domain reset; restarts the PLL on lock loss.
module flash_pll_supervisor
  import flash_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         pll_lock,
  input  logic         restart,
  output logic         pll_reset,
  output logic         flash_rst_n,
  output logic         ready,
  output logic         fail,
  output logic [2:0]   retry_cnt
);

  // Reject parameter values the 16-bit shared counter cannot represent.
  if (PLL_RST_CYCLES < 2 || PLL_RST_CYCLES > CNT_MAX_LOAD) begin : g_bad_rst_cycles
    $error("PLL_RST_CYCLES must be in 2..65536");
  end
  if (LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > CNT_MAX_LOAD) begin : g_bad_lock_timeout
    $error("LOCK_TIMEOUT must be in 1..65536");
  end
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > CNT_MAX_LOAD) begin : g_bad_stable_cycles
    $error("STABLE_CYCLES must be in 1..65536");
  end
  if (MAX_RETRIES < 1 || MAX_RETRIES > 7) begin : g_bad_max_retries
    $error("MAX_RETRIES must be in 1..7");
  end

  localparam logic [CNT_W-1:0]   RST_LOAD    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LOAD     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LOAD = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] RETRY_SAT   = '1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 pll_reset_q, pll_reset_d;
  logic                 flash_rst_n_q, flash_rst_n_d;
  logic                 ready_q, ready_d;
  logic                 fail_q, fail_d;

  logic                 lock_s;
  logic                 cnt_zero;
  logic [RETRY_W-1:0]   retry_inc;

  sync2 #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign cnt_zero  = (cnt_q == '0);
  assign retry_inc = (retry_q == RETRY_SAT) ? retry_q : retry_q + RETRY_W'(1);

  // Next state, shared counter reload/decrement, retry bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;

    if (restart) begin
      state_d = ST_PLL_RST;
      cnt_d   = RST_LOAD;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_PLL_RST: begin
          if (cnt_zero) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = TO_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
            cnt_d   = STABLE_LOAD;
          end else if (cnt_zero) begin
            retry_d = retry_inc;
            if (retry_inc >= RETRY_MAX) begin
              state_d = ST_FAIL;
              cnt_d   = '0;
            end else begin
              state_d = ST_PLL_RST;
              cnt_d   = RST_LOAD;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = TO_LOAD;
          end else if (cnt_zero) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_PLL_RST;
            cnt_d   = RST_LOAD;
            retry_d = retry_inc;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_PLL_RST;
          cnt_d   = RST_LOAD;
        end
      endcase
    end
  end

  // Output decode from the next state so the registered outputs track the state register.
  always_comb begin
    pll_reset_d   = (state_d == ST_PLL_RST);
    flash_rst_n_d = (state_d == ST_RUN);
    ready_d       = (state_d == ST_RUN);
    fail_d        = (state_d == ST_FAIL);
  end

  // State, counter, retry count and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_PLL_RST;
      cnt_q         <= RST_LOAD;
      retry_q       <= '0;
      pll_reset_q   <= 1'b1;
      flash_rst_n_q <= 1'b0;
      ready_q       <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      pll_reset_q   <= pll_reset_d;
      flash_rst_n_q <= flash_rst_n_d;
      ready_q       <= ready_d;
      fail_q        <= fail_d;
    end
  end

  assign pll_reset   = pll_reset_q;
  assign flash_rst_n = flash_rst_n_q;
  assign ready       = ready_q;
  assign fail        = fail_q;
  assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_flash_pll_supervisor.sv
// Self-checking bench for flash_pll_supervisor: vector table, directed
// corner sequences, then random lock/restart traffic against a reference model.
module tb_flash_pll_supervisor;

  localparam int unsigned P_RST = 16;
  localparam int unsigned P_TO  = 300;
  localparam int unsigned P_ST  = 100;
  localparam int unsigned P_MR  = 7;
  localparam int          E     = P_RST + P_TO;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       restart = 1'b0;
  logic       pll_reset, flash_rst_n, ready, fail;
  logic [2:0] retry_cnt;
  logic [6:0] obs;

  int n_err = 0;
  int n_checks = 0;

  flash_pll_supervisor #(
    .PLL_RST_CYCLES (P_RST),
    .LOCK_TIMEOUT   (P_TO),
    .STABLE_CYCLES  (P_ST),
    .MAX_RETRIES    (P_MR)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pll_lock    (pll_lock),
    .restart     (restart),
    .pll_reset   (pll_reset),
    .flash_rst_n (flash_rst_n),
    .ready       (ready),
    .fail        (fail),
    .retry_cnt   (retry_cnt)
  );

  always #5 clk = ~clk;

  // {pll_reset, flash_rst_n, ready, fail, retry_cnt}
  assign obs = {pll_reset, flash_rst_n, ready, fail, retry_cnt};

  // Reference model: phase name plus cycles elapsed in it, lock seen two edges late.
  localparam int M_RST = 0, M_WAIT = 1, M_STABLE = 2, M_RUN = 3, M_FAIL = 4;

  typedef struct packed {
    int st;
    int el;
    int retry;
    bit h0;
    bit h1;
  } model_t;

  model_t m = '0;

  function automatic model_t model_step(model_t cur, bit lock_in, bit rs);
    model_t nx;
    bit ls;
    int spent;
    nx    = cur;
    ls    = cur.h1;
    nx.h1 = cur.h0;
    nx.h0 = lock_in;
    spent = cur.el + 1;
    nx.el = spent;
    if (rs) begin
      nx.st = M_RST; nx.el = 0; nx.retry = 0;
    end else begin
      case (cur.st)
        M_RST:    if (spent >= P_RST) begin nx.st = M_WAIT; nx.el = 0; end
        M_WAIT: begin
          if (ls) begin
            nx.st = M_STABLE; nx.el = 0;
          end else if (spent >= P_TO) begin
            nx.retry = (cur.retry >= 7) ? 7 : cur.retry + 1;
            nx.st    = (nx.retry >= P_MR) ? M_FAIL : M_RST;
            nx.el    = 0;
          end
        end
        M_STABLE: begin
          if (!ls) begin
            nx.st = M_WAIT; nx.el = 0;
          end else if (spent >= P_ST) begin
            nx.st = M_RUN; nx.el = 0;
          end
        end
        M_RUN: begin
          if (!ls) begin
            nx.st = M_RST; nx.el = 0;
            nx.retry = (cur.retry >= 7) ? 7 : cur.retry + 1;
          end
        end
        default: nx.st = M_FAIL;
      endcase
    end
    return nx;
  endfunction

  function automatic logic [6:0] model_out(model_t cur);
    return {cur.st == M_RST, cur.st == M_RUN, cur.st == M_RUN, cur.st == M_FAIL, 3'(cur.retry)};
  endfunction

  // Advance the model on the same edges as the design.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= '0;
    else          m <= model_step(m, pll_lock, restart);
  end

  task automatic check_vec(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (pll_reset,flash_rst_n,ready,fail,retry)", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Count consecutive sampled cycles with pll_reset high, starting with the current one.
  task automatic measure_rst_pulse(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!pll_reset) break;
      n++;
      @(negedge clk);
    end
  endtask

  // Count clock cycles until ready is seen high; also reports any pll_reset seen meanwhile.
  task automatic wait_ready(output int n, output bit saw_rst);
    n = 0;
    saw_rst = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      n++;
      if (pll_reset) saw_rst = 1'b1;
      if (ready) break;
    end
  endtask

  typedef struct {
    logic       rn;
    logic       lock;
    logic       rs;
    int         cycles;
    logic [6:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int  n;
    bit  saw;
    int  hold;

    // Timeout / retry / FAIL / restart-from-FAIL vectors, lock held low.
    tbl.push_back('{1'b0, 1'b0, 1'b0, 2,                  7'b1000000, "reset_state"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, P_RST - 1,          7'b1000000, "rst_pulse_last_cycle"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1,                  7'b0000000, "rst_pulse_end"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, P_TO - 1,           7'b0000000, "timeout_last_wait_cycle"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1,                  7'b1000001, "timeout1_retry"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, P_RST,              7'b0000001, "retry1_wait"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 6*E - P_RST - 1,    7'b0000110, "before_7th_timeout"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1,                  7'b0001111, "fail_entered"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 500,                7'b0001111, "fail_sticky"});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1,                  7'b1000000, "restart_from_fail"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 5,                  7'b1000000, "after_restart"});

    @(negedge clk);
    foreach (tbl[i]) begin
      reset_n  = tbl[i].rn;
      pll_lock = tbl[i].lock;
      restart  = tbl[i].rs;
      repeat (tbl[i].cycles) @(negedge clk);
      check_vec(tbl[i].name, obs, tbl[i].exp);
    end
    restart = 1'b0;

    // Normal bring-up.
    reset_n = 1'b0;
    pll_lock = 1'b0;
    @(negedge clk);
    check_vec("bringup_reset_state", obs, 7'b1000000);
    reset_n = 1'b1;
    measure_rst_pulse(n);
    check_int("bringup_pll_reset_width", n, P_RST);
    repeat (100) @(negedge clk);
    pll_lock = 1'b1;
    wait_ready(n, saw);
    check_int("bringup_ready_latency", n, 2 + P_ST + 1);
    check_vec("bringup_run_outputs", obs, 7'b0110000);

    // Lock loss in RUN.
    pll_lock = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n++;
      if (!flash_rst_n) break;
    end
    check_range("runloss_flash_rst_latency", n, 1, 3);
    check_vec("runloss_outputs", obs, 7'b1000001);
    measure_rst_pulse(n);
    check_int("runloss_pll_reset_width", n, P_RST);
    check_vec("runloss_after_pulse", obs, 7'b0000001);

    // One-cycle lock glitch partway into STABLE.
    pll_lock = 1'b1;
    repeat (3 + P_ST / 2) @(negedge clk);
    check_vec("glitch_in_stable", obs, 7'b0000001);
    pll_lock = 1'b0;
    @(negedge clk);
    pll_lock = 1'b1;
    wait_ready(n, saw);
    check_int("glitch_ready_latency", n, 2 + P_ST + 1);
    check_int("glitch_no_pll_reset", int'(saw), 0);
    check_vec("glitch_run_outputs", obs, 7'b0110001);

    // Restart in RUN coinciding with a synchronized lock drop.
    pll_lock = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_vec("restart_run_still_ready", obs, 7'b0110001);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check_vec("restart_run_outputs", obs, 7'b1000000);
    measure_rst_pulse(n);
    check_int("restart_pll_reset_width", n, P_RST);

    // Asynchronous reset while in STABLE.
    pll_lock = 1'b1;
    repeat (3 + 20) @(negedge clk);
    check_vec("async_pre_stable", obs, 7'b0000000);
    #2;
    reset_n = 1'b0;
    #1;
    check_vec("async_reset_outputs", obs, 7'b1000000);
    @(negedge clk);
    reset_n = 1'b1;
    measure_rst_pulse(n);
    check_int("async_release_pll_reset_width", n, P_RST);

    // Random lock/restart traffic against the reference model.
    reset_n = 1'b0;
    pll_lock = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    hold = 0;
    for (int c = 0; c < 7000; c++) begin
      @(negedge clk);
      check_vec("rand_cycle", obs, model_out(m));
      if (c >= 3000 && c < 5600) begin
        pll_lock = 1'b0;
        restart  = 1'b0;
      end else begin
        if (hold == 0) begin
          pll_lock = ($urandom_range(0, 99) < 70);
          hold     = $urandom_range(1, 220);
        end
        hold--;
        restart = ($urandom_range(0, 299) == 0);
      end
    end
    restart = 1'b0;
    @(negedge clk);
    check_vec("rand_final", obs, model_out(m));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
